// File: rtl/ov7670_config_sequencer_if.sv
// Command/table/status bundle between the config sequencer and its neighbours.
// master = sequencer side; slave = table ROM, I2C sender and top-level status.
interface ov7670_config_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] tbl_addr;
   logic [15:0]       tbl_data;
   logic              send;
   logic              taken;
   logic [7:0]        id;
   logic [7:0]        rega;
   logic [7:0]        value;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] count;

   modport master (
      input  start, tbl_data, taken,
      output tbl_addr, send, id, rega, value, busy, done, error, count
   );

   modport slave (
      output start, tbl_data, taken,
      input  tbl_addr, send, id, rega, value, busy, done, error, count
   );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the camera register table, issuing one SCCB write per entry via send/taken,
// with delay entries, an end marker and a watchdog on the sender's acceptance.
module ov7670_config_sequencer #(
   parameter int         ADDR_W         = 8,
   parameter logic [7:0] DEVICE_ID      = 8'h42,
   parameter int         DELAY_CYCLES   = 1000000,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         AUTO_START     = 1
) (
   input  logic                       clk,
   input  logic                       clr,
   ov7670_config_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DELAY, S_DONE, S_ERROR
   } state_t;

   localparam logic [15:0] END_MARK = 16'hFFFF;
   localparam logic [15:0] DLY_MARK = 16'hF0F0;
   localparam logic [23:0] DLY_LAST = 24'(DELAY_CYCLES - 1);
   localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_count;
   logic [7:0]        r_rega;
   logic [7:0]        r_value;
   logic [23:0]       r_dly;
   logic [23:0]       r_to;
   logic              r_auto;

   logic w_restart;
   logic w_accept;
   logic w_dly_end;
   logic w_last;
   logic w_is_end;
   logic w_is_dly;

   assign w_last   = &r_addr;
   assign w_is_end = (bus.tbl_data == END_MARK);
   assign w_is_dly = (bus.tbl_data == DLY_MARK);

   always_comb begin
      w_next    = r_state;
      w_restart = 1'b0;
      w_accept  = 1'b0;
      w_dly_end = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start || r_auto) begin
               w_next    = S_FETCH;
               w_restart = 1'b1;
            end
         end
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (w_is_end)      w_next = S_DONE;
            else if (w_is_dly) w_next = S_DELAY;
            else               w_next = S_ISSUE;
         end
         S_ISSUE: begin
            // An acceptance on the final watchdog cycle takes priority over the error.
            if (bus.taken) begin
               w_accept = 1'b1;
               w_next   = w_last ? S_DONE : S_FETCH;
            end else if (r_to == TO_LAST) begin
               w_next = S_ERROR;
            end
         end
         S_DELAY: begin
            if (r_dly == DLY_LAST) begin
               w_dly_end = 1'b1;
               w_next    = w_last ? S_DONE : S_FETCH;
            end
         end
         S_DONE, S_ERROR: begin
            if (bus.start) begin
               w_next    = S_FETCH;
               w_restart = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_count <= '0;
         r_rega  <= '0;
         r_value <= '0;
         r_dly   <= '0;
         r_to    <= '0;
         r_auto  <= (AUTO_START != 0);
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) r_auto <= 1'b0;

         // The table never wraps: the last address ends the run instead.
         if (w_restart)
            r_addr <= '0;
         else if ((w_accept || w_dly_end) && !w_last)
            r_addr <= r_addr + ADDR_W'(1);

         if (w_restart)
            r_count <= '0;
         else if (w_accept && !(&r_count))
            r_count <= r_count + ADDR_W'(1);

         if (r_state == S_DECODE) begin
            r_dly <= '0;
            r_to  <= '0;
            if (!w_is_end && !w_is_dly) begin
               r_rega  <= bus.tbl_data[15:8];
               r_value <= bus.tbl_data[7:0];
            end
         end
         if (r_state == S_ISSUE) r_to  <= r_to + 24'd1;
         if (r_state == S_DELAY) r_dly <= r_dly + 24'd1;
      end
   end

   assign bus.tbl_addr = r_addr;
   assign bus.send     = (r_state == S_ISSUE);
   assign bus.id       = DEVICE_ID;
   assign bus.rega     = r_rega;
   assign bus.value    = r_value;
   assign bus.busy     = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_ISSUE) || (r_state == S_DELAY);
   assign bus.done     = (r_state == S_DONE);
   assign bus.error    = (r_state == S_ERROR);
   assign bus.count    = r_count;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: directed tables plus random tables and taken latencies,
// checked against a table-walking model that predicts each command, its timing and final status.
module tb_ov7670_config_sequencer;

   localparam int AW   = 3;
   localparam int MAXA = (1 << AW) - 1;
   localparam int DLY  = 10;
   localparam int TO   = 20;

   logic clk;
   logic clr;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [15:0] rom [0:MAXA];

   ov7670_config_sequencer_if #(.ADDR_W(AW)) bus ();

   ov7670_config_sequencer #(
      .ADDR_W(AW), .DEVICE_ID(8'h42), .DELAY_CYCLES(DLY),
      .TIMEOUT_CYCLES(TO), .AUTO_START(1)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   assign bus.tbl_data = rom[bus.tbl_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // sel: 0 send, 1 done, 2 error. Returns the cycle seen, or -1 when the budget runs out.
   task automatic wait_for(input int sel, input int budget, output int at);
      logic hit;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         hit = (sel == 0) ? bus.send : (sel == 1) ? bus.done : bus.error;
         if (hit === 1'b1) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_start(output int f);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      f = cyc;
      check("start_busy", bus.busy, 1);
      check("start_addr", bus.tbl_addr, 0);
      check("start_cnt", bus.count, 0);
      check("start_flags", {bus.done, bus.error}, 0);
   endtask

   // Model: FETCH entered at edge f; a write raises send at f+2, a delay entry moves
   // the next FETCH to f+2+DLY, the end marker gives done at f+2; an accepted write
   // at edge t starts the next FETCH at t (or ends the run at t on the last address).
   task automatic run_table(input int lat_lo, input int lat_hi, input int f0,
                            input bit exp_to, input bit poke_start);
      int a = 0;
      int f = f0;
      int cnt = 0;
      int at, at2, lat, t, exp_done;
      bit pend = 0;
      bit fin = 0;
      while (!fin) begin
         if (!pend) begin
            while (!pend && rom[a] == 16'hF0F0) begin
               f = f + 2 + DLY;
               if (a == MAXA) begin pend = 1; exp_done = f; end
               else a++;
            end
            if (!pend && rom[a] == 16'hFFFF) begin pend = 1; exp_done = f + 2; end
         end
         if (pend) begin
            wait_for(1, 3000, at);
            check("done_time", at, exp_done);
            check("done_cnt", bus.count, cnt);
            check("done_addr", bus.tbl_addr, a);
            check("done_idle", {bus.busy, bus.send, bus.error}, 0);
            fin = 1;
         end else begin
            wait_for(0, 3000, at);
            check("rise_time", at, f + 2);
            check("rega", bus.rega, rom[a][15:8]);
            check("value", bus.value, rom[a][7:0]);
            check("issue_addr", bus.tbl_addr, a);
            if (at < 0) begin
               fin = 1;
            end else if (exp_to) begin
               wait_for(2, 3000, at2);
               check("err_time", at2, at + TO);
               check("err_send", bus.send, 0);
               check("err_cnt", bus.count, cnt);
               check("err_busy", bus.busy, 0);
               fin = 1;
            end else begin
               lat = $urandom_range(lat_hi, lat_lo);
               for (int i = 0; i < lat; i++) begin
                  bus.start = (poke_start && i == 0);
                  @(negedge clk);
               end
               bus.start = 1'b0;
               check("held_send", bus.send, 1);
               check("held_addr", bus.tbl_addr, a);
               check("held_cnt", bus.count, cnt);
               check("held_rega", bus.rega, rom[a][15:8]);
               bus.taken = 1'b1;
               @(negedge clk);
               bus.taken = 1'b0;
               t = cyc;
               if (cnt < MAXA) cnt++;
               check("acc_cnt", bus.count, cnt);
               check("acc_send", bus.send, 0);
               if (a == MAXA) begin pend = 1; exp_done = t; end
               else begin a++; f = t; end
            end
         end
      end
   endtask

   int f;
   int at;
   logic [15:0] w;

   initial begin
      bus.start = 1'b0;
      bus.taken = 1'b0;
      clr = 1'b1;
      for (int i = 0; i <= MAXA; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'h1280; rom[1] = 16'h1204;

      repeat (3) @(negedge clk);
      check("rst_addr", bus.tbl_addr, 0);
      check("rst_out", {bus.send, bus.busy, bus.done, bus.error}, 0);
      check("rst_regval", {bus.rega, bus.value}, 0);
      check("rst_cnt", bus.count, 0);
      check("rst_id", bus.id, 8'h42);

      // Normal run via auto start: first edge seeing clr low enters FETCH.
      clr = 1'b0;
      run_table(5, 5, cyc + 1, 0, 0);

      // Delay entry: accept-to-next-rise gap is DLY+4 edges.
      rom[0] = 16'h1280; rom[1] = 16'hF0F0; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
      do_start(f);
      run_table(5, 5, f, 0, 0);

      // Watchdog, then restart reissues entry 0.
      rom[0] = 16'h1280; rom[1] = 16'hFFFF;
      do_start(f);
      run_table(0, 0, f, 1, 0);
      do_start(f);
      run_table(2, 6, f, 0, 0);

      // taken on the last watchdog cycle wins over the error.
      do_start(f);
      run_table(TO - 1, TO - 1, f, 0, 0);

      // start during ISSUE is ignored.
      rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
      do_start(f);
      run_table(2, 6, f, 0, 1);

      // clr in ISSUE of the second write, then auto restart from entry 0.
      do_start(f);
      wait_for(0, 100, at);
      bus.taken = 1'b1; @(negedge clk); bus.taken = 1'b0;
      @(negedge clk);
      wait_for(0, 100, at);
      check("pre_clr_cnt", bus.count, 1);
      clr = 1'b1;
      @(negedge clk);
      check("clr_send", bus.send, 0);
      check("clr_busy", bus.busy, 0);
      check("clr_cnt", bus.count, 0);
      check("clr_addr", bus.tbl_addr, 0);
      clr = 1'b0;
      run_table(1, 8, cyc + 1, 0, 0);

      // No end marker: count saturates and the address does not wrap.
      for (int i = 0; i <= MAXA; i++) rom[i] = 16'h1000 + 16'(i * 16'h0101);
      do_start(f);
      run_table(2, 4, f, 0, 0);

      // Random tables with random acceptance latency.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i <= MAXA; i++) begin
            case ($urandom_range(9, 0))
               0: rom[i] = 16'hF0F0;
               1: rom[i] = 16'hFFFF;
               default: begin
                  w = 16'($urandom);
                  if (w == 16'hFFFF || w == 16'hF0F0) w = 16'h0001;
                  rom[i] = w;
               end
            endcase
         end
         do_start(f);
         run_table(0, TO - 1, f, 0, it[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Walks a register table and issues one camera register write per entry through the SCCB/I2C sender, using its `send`/`taken` handshake. It sits between a register table (ROM) and the I2C sender in the camera controller. It provides:
- automatic start after reset, or a restart on request;
- delay entries for sensor settling after soft reset;
- a watchdog that flags a sender that never accepts a command;
- busy, done and error status for the top level.

## Interface
Parameters:
- ADDR_W, 8: table address width; table depth is 2^ADDR_W entries.
- DEVICE_ID, 8'h42: SCCB write address driven on `id`.
- DELAY_CYCLES, 1000000: clk cycles spent on a delay entry; must be ≥1 and < 2^24.
- TIMEOUT_CYCLES, 65535: maximum cycles in ISSUE without `taken` before error; must be ≥1 and < 2^24.
- AUTO_START, 1: if 1, a sequence begins automatically after reset.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to (re)run the table from entry 0.
- tbl_addr  out  ADDR_W  table address.
- tbl_data  in  16  table entry, {register, value}. Combinational or 1-cycle registered read.
- send  out  1  command valid to the I2C sender.
- taken  in  1  one-cycle acceptance pulse from the I2C sender.
- id  out  8  constant DEVICE_ID.
- rega  out  8  register address of the current command.
- value  out  8  register data of the current command.
- busy  out  1  high while a sequence is running.
- done  out  1  high after the end marker is reached, until the next start.
- error  out  1  high after a timeout, until the next start.
- count  out  ADDR_W  number of writes accepted in the current run.

## Operation
Special entries:
- 16'hFFFF: end of table.
- 16'hF0F0: delay entry.

All other values are register writes.

States: IDLE, FETCH, DECODE, ISSUE, DELAY, DONE, ERROR.

- **IDLE**: `busy`=0. Moves to FETCH on `start`. Also moves to FETCH on the first cycle after `clr` falls when AUTO_START=1.
- **FETCH**: sets `tbl_addr`, waits 1 cycle for the ROM, then goes to DECODE.
- **DECODE**: samples `tbl_data`.
  - 16'hFFFF → DONE.
  - 16'hF0F0 → DELAY; the delay counter is cleared.
  - Otherwise loads `rega`=tbl_data[15:8] and `value`=tbl_data[7:0], then → ISSUE.
- **ISSUE**: `send`=1 while `rega`/`value` are held stable.
  - On the cycle `taken`=1: `count`++, `send` goes to 0 on the next cycle, and the address advances (see ADVANCE).
  - If TIMEOUT_CYCLES elapse without `taken` → ERROR.
- **DELAY**: counts DELAY_CYCLES cycles with `send`=0, then does ADVANCE.
- **ADVANCE**: if `tbl_addr` = 2^ADDR_W−1 → DONE (no wrap). Otherwise `tbl_addr`++ → FETCH.
- **DONE**: `done`=1, `busy`=0, `send`=0. On `start` → FETCH.
- **ERROR**: `error`=1, `busy`=0, `send`=0. On `start` → FETCH.
- **Leaving DONE, ERROR or IDLE on `start`**: `tbl_addr`=0, `count`=0, and `done`/`error` are cleared in the same edge.

Rules:
- `start` in FETCH, DECODE, ISSUE or DELAY is ignored.
- `taken` outside ISSUE is ignored.
- `busy`=1 in FETCH, DECODE, ISSUE and DELAY.
- `count` saturates at 2^ADDR_W−1.

## Timing
- **Reset values**: `tbl_addr`=0, `send`=0, `rega`=0, `value`=0, `busy`=0, `done`=0, `error`=0, `count`=0, `id`=DEVICE_ID, state=IDLE.
- **Reset mid-operation**: `clr` during any state forces the reset values on the next edge. `send` drops the same edge; no partial command is retried.
- **Start latency**: `start` high at edge N → FETCH at N+1 and `busy`=1 from N+1. The first `send`=1 appears at N+3 (FETCH, DECODE, ISSUE).
- **Handshake**: `send` stays high continuously from ISSUE entry until the edge after `taken`. The next command's `send` rises 3 cycles after `taken` (FETCH, DECODE, ISSUE).
- **Delay entry**: `taken`-free. Lasts DELAY_CYCLES + 1 cycles from DECODE to the next FETCH.
- **Timeout**: counted from ISSUE entry. ERROR is entered on the edge where the counter reaches TIMEOUT_CYCLES. A `taken` arriving on that same cycle wins: the write is accepted and there is no error.
- **End marker**: `done` is asserted 1 cycle after DECODE samples 16'hFFFF.

## Test plan
- **Normal run**: AUTO_START=1 and table {1280, 1204, FFFF}; `taken` pulsed 5 cycles after each `send` rise → rega/value = 12/80 then 12/04; `count`=2; `done`=1; `busy`=0; `send`=0 after the last `taken`.
- **Delay entry**: DELAY_CYCLES=10 and table {1280, F0F0, 3A04, FFFF} → the gap between the first `taken` and the second `send` rise is 14 cycles; `count`=2 at done.
- **Timeout**: TIMEOUT_CYCLES=20 and `taken` never asserted → `error`=1 exactly 20 cycles after `send` rises; `send`=0; `count`=0. A following `start` clears `error` and reissues entry 0.
- **Start while busy**: `start` pulsed during ISSUE → no effect; `tbl_addr` and `count` are unchanged.
- **Reset mid-command**: `clr` in ISSUE → next edge shows `send`=0, `busy`=0, `count`=0, `tbl_addr`=0; with AUTO_START=1 the table restarts from entry 0.
- **No end marker**: ADDR_W=2 and 4 write entries → 4 `taken` cycles, then `done`=1 with `count`=3 (saturated); `tbl_addr` does not wrap.
